// File: rtl/popcnt_pkg.sv
`default_nettype none
// popcnt_pkg: shared types and constants for the popcount scheduler (rev 1.0).
package popcnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int ENG_LATENCY = 7;
  localparam int ENG_GAP     = 2;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_CNT_W   = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter: combinational round-robin pick starting at an external pointer (rev 1.0).
module rr_arbiter
  import popcnt_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   ptr,
  output logic [N-1:0]              gnt,
  output logic [idx_width(N)-1:0]   gnt_idx,
  output logic                      any
);

  localparam int IW = idx_width(N);

  int cand;

  // Walk the requesters in order ptr, ptr+1, ... with wrap; the first hit wins.
  always_comb begin
    cand    = 0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!any && req[IW'(cand)]) begin
        any     = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
  end

  assign gnt = any ? (N'(1) << gnt_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/popcnt_sched.sv
`default_nettype none
// popcnt_sched: round-robin sharing of one pipelined popcount engine with timeout (rev 1.0).
module popcnt_sched
  import popcnt_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [CNT_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    eng_in_valid,
  output logic [DATA_W-1:0]       eng_A,
  input  logic                    eng_out_valid,
  input  logic [CNT_W-1:0]        eng_out_data,
  output logic                    err_sticky
);

  localparam int PTR_W = idx_width(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  // Cycles from a result strobe to the next issue strobe: RESP, IDLE, then ISSUE.
  localparam int REISSUE_GAP = 3;

  if (TIMEOUT <= ENG_LATENCY) begin : g_bad_timeout
    $error("popcnt_sched: TIMEOUT must exceed the engine latency");
  end

  if (REISSUE_GAP <= ENG_GAP) begin : g_bad_gap
    $error("popcnt_sched: reissue path too short for the engine sequencing window");
  end

  state_t              state;
  state_t              state_nxt;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    ptr_nxt;
  logic [PTR_W-1:0]    owner;
  logic [PTR_W-1:0]    gnt_idx;
  logic [N_REQ-1:0]    gnt;
  logic                any_req;
  logic                accept;
  logic                timer_done;
  logic                owner_rsp_ready;
  logic [TMR_W-1:0]    timer;
  logic [DATA_W-1:0]   sel_operand;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  // Grant is only visible in IDLE; masking with rst keeps req_ready low during reset.
  assign accept          = (state == IDLE) && any_req && !rst;
  assign req_ready       = accept ? gnt : '0;
  assign sel_operand     = req_data[gnt_idx*DATA_W +: DATA_W];
  assign ptr_nxt         = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign timer_done      = (timer == TMR_W'(TIMEOUT));
  assign owner_rsp_ready = rsp_ready[owner];
  assign eng_in_valid    = (state == ISSUE);
  assign rsp_valid       = (state == RESP) ? (N_REQ'(1) << owner) : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (eng_out_valid || timer_done) state_nxt = RESP;
      RESP:    if (owner_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration bookkeeping; eng_A keeps the last operand after the issue cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      owner <= '0;
      eng_A <= '0;
    end else if (state == IDLE && any_req) begin
      ptr   <= ptr_nxt;
      owner <= gnt_idx;
      eng_A <= sel_operand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state == ISSUE) begin
      timer <= '0;
    end else if (state == WAIT && !timer_done) begin
      timer <= timer + 1'b1;
    end
  end

  // A real result takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (state == WAIT) begin
      if (eng_out_valid) begin
        rsp_data <= eng_out_data;
        rsp_err  <= 1'b0;
      end else if (timer_done) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (state == WAIT && timer_done && !eng_out_valid) begin
      err_sticky <= 1'b1;
    end else if (state != WAIT && eng_out_valid) begin
      err_sticky <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_popcnt_sched.sv
`default_nettype none
// tb_popcnt_sched: directed and randomized bench with a transaction-level reference model.
module tb_popcnt_sched;

  localparam int N   = 4;
  localparam int DW  = 128;
  localparam int CW  = 8;
  localparam int TMO = 15;
  localparam int RSP_DELAY = 9;  // accept -> issue (+1) -> result (+7) -> response (+1)

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [CW-1:0]     rsp_data;
  logic              rsp_err;
  logic              eng_in_valid;
  logic [DW-1:0]     eng_A;
  logic              eng_out_valid;
  logic [CW-1:0]     eng_out_data;
  logic              err_sticky;

  popcnt_sched #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .CNT_W   (CW),
    .TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .eng_in_valid  (eng_in_valid),
    .eng_A         (eng_A),
    .eng_out_valid (eng_out_valid),
    .eng_out_data  (eng_out_data),
    .err_sticky    (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int cyc;

  logic [N-1:0]  valid_s;
  logic [N-1:0]  ready_s;
  logic [DW-1:0] op [N];
  bit            auto_drop;
  bit            rand_mode;

  int            eng_cnt;
  logic [CW-1:0] eng_pc;
  bit            eng_suppress;
  bit            spur_req;
  bit            spur_now;

  int            m_ptr;
  int            m_owner;
  int            m_ta;
  int            m_rsp_at;
  bit            m_busy;
  bit            m_err;
  bit            m_err_next;
  bit            m_tmo;
  logic [CW-1:0] m_data;
  int            obs_grants[$];
  int            ein_cyc[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_op();
    logic [DW-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      default: v = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v;
  endfunction

  // Engine model: answers 7 cycles after the issue strobe unless suppressed.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    spur_now      = 1'b0;
    eng_out_valid = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && !eng_suppress) begin
        eng_out_valid = 1'b1;
        eng_out_data  = eng_pc;
      end
    end
    if (spur_req) begin
      eng_out_valid = 1'b1;
      eng_out_data  = 8'd55;
      spur_req      = 1'b0;
      spur_now      = 1'b1;
    end
    if (eng_in_valid) begin
      eng_cnt = 7;
      eng_pc  = CW'($countones(eng_A));
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;
    int g;
    int idx;
    exp_gnt = '0;
    g = -1;
    if (m_err_next) begin
      m_err      = 1'b1;
      m_err_next = 1'b0;
    end
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_gnt = N'(1) << g;
    chk("req_ready", req_ready, exp_gnt);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) obs_grants.push_back(i);
    end
    chk("eng_in_valid", eng_in_valid, m_busy && (cyc == m_ta + 1));
    if (eng_in_valid) ein_cyc.push_back(cyc);
    exp_rv = (m_busy && cyc >= m_rsp_at) ? (N'(1) << m_owner) : '0;
    if (m_busy && m_tmo && cyc == m_rsp_at) m_err = 1'b1;
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv != 0) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_err", rsp_err, m_tmo);
    end
    chk("err_sticky", err_sticky, m_err);
    if (spur_now) m_err_next = 1'b1;
    if (g >= 0) begin
      m_busy   = 1'b1;
      m_owner  = g;
      m_ta     = cyc;
      m_tmo    = eng_suppress;
      m_rsp_at = eng_suppress ? (cyc + 1 + TMO + 2) : (cyc + RSP_DELAY);
      m_data   = eng_suppress ? '0 : CW'($countones(op[g]));
      m_ptr    = (g + 1) % N;
      if (auto_drop) valid_s[g] = 1'b0;
    end else if (exp_rv != 0 && rsp_ready[m_owner]) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic cycle();
    tick();
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!valid_s[i] && $urandom_range(0, 3) == 0) begin
          valid_s[i] = 1'b1;
          op[i]      = rand_op();
        end
        ready_s[i] = ($urandom_range(0, 3) != 0);
      end
    end
    req_valid = valid_s;
    rsp_ready = ready_s;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = op[i];
    #1;
    check_cycle();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      done = (valid_s == '0) && !m_busy;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_eng_in_valid", eng_in_valid, 1'b0);
    chk("rst_eng_A", eng_A, '0);
    chk("rst_err_sticky", err_sticky, 1'b0);
    eng_cnt       = 0;
    eng_out_valid = 1'b0;
    spur_req      = 1'b0;
    spur_now      = 1'b0;
    m_busy        = 1'b0;
    m_ptr         = 0;
    m_err         = 1'b0;
    m_err_next    = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    valid_s = '0;
    ready_s = '0;
    req_valid = '0;
    rsp_ready = '0;
    req_data = '0;
    eng_out_valid = 1'b0;
    eng_out_data = '0;
    for (int i = 0; i < N; i++) op[i] = '0;
    do_reset();

    // Single request with an all-ones operand.
    op[0] = '1;
    valid_s = 4'b0001;
    ready_s = '1;
    auto_drop = 1'b1;
    obs_grants.delete();
    wait_idle("single_done", 30);
    chk("single_grants", obs_grants.size(), 1);

    // Round robin with every requester holding its request.
    do_reset();
    for (int i = 0; i < N; i++) begin
      op[i] = '0;
      for (int j = 0; j <= i; j++) op[i][j] = 1'b1;
    end
    valid_s = '1;
    auto_drop = 1'b0;
    obs_grants.delete();
    ein_cyc.delete();
    for (int i = 0; i < 80 && obs_grants.size() < 5; i++) cycle();
    valid_s = '0;
    wait_idle("rr_done", 30);
    chk("rr_grant_count", obs_grants.size(), 5);
    for (int i = 0; i < obs_grants.size() && i < 5; i++) chk("rr_grant_order", obs_grants[i], i % N);
    for (int i = 1; i < ein_cyc.size(); i++) chk("rr_issue_gap", ein_cyc[i] - ein_cyc[i-1], 10);

    // Response backpressure on requester 2 while others wait.
    auto_drop = 1'b1;
    op[2] = rand_op();
    valid_s = 4'b0100;
    ready_s = 4'b1011;
    for (int i = 0; i < 30 && !(m_busy && cyc >= m_rsp_at); i++) cycle();
    chk("bp_rsp_valid", rsp_valid, 4'b0100);
    op[0] = rand_op();
    op[1] = rand_op();
    op[3] = rand_op();
    valid_s = 4'b1011;
    ein_cyc.delete();
    repeat (20) cycle();
    chk("bp_no_issue", ein_cyc.size(), 0);
    ready_s = '1;
    wait_idle("bp_done", 80);

    // Randomized traffic with random response backpressure.
    rand_mode = 1'b1;
    repeat (600) cycle();
    rand_mode = 1'b0;
    ready_s = '1;
    wait_idle("rand_done", 200);

    // Engine never answers.
    eng_suppress = 1'b1;
    op[3] = rand_op();
    valid_s = 4'b1000;
    wait_idle("timeout_done", 40);
    eng_suppress = 1'b0;
    chk("timeout_sticky", err_sticky, 1'b1);

    // Reset while the engine is working; pointer must restart at 0.
    op[1] = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    valid_s = 4'b0010;
    for (int i = 0; i < 30 && !(m_busy && cyc == m_ta + 4); i++) cycle();
    do_reset();
    op[1] = 128'h0F;
    op[3] = rand_op();
    valid_s = 4'b1010;
    obs_grants.delete();
    wait_idle("post_reset_done", 60);
    chk("post_reset_first_grant", (obs_grants.size() > 0) ? obs_grants[0] : -1, 1);

    // Result strobe with nothing in flight.
    spur_req = 1'b1;
    repeat (6) cycle();
    chk("spur_sticky", err_sticky, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
